// File: rtl/slice_alu_if.sv
// Request/result handshake bundle for the slice-serial ALU.
// master issues operations and takes results; slave is the ALU.
interface slice_alu_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [3:0]       S;
   logic             M;
   logic             Pin;
   logic             acc_sel;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] R;
   logic             Pout;
   logic             zero;
   logic             eq;

   modport master (
      output in_valid, A, B, S, M, Pin, acc_sel, out_ready,
      input  in_ready, out_valid, R, Pout, zero, eq
   );

   modport slave (
      input  in_valid, A, B, S, M, Pin, acc_sel, out_ready,
      output in_ready, out_valid, R, Pout, zero, eq
   );
endinterface

// File: rtl/slice_alu.sv
// Slice-serial ALU: one 4-bit slice per cycle, LSB first.
// Result and flags change only when an operation completes.
module slice_alu #(
   parameter int WIDTH = 16
) (
   input logic        clk,
   input logic        rst,
   slice_alu_if.slave bus
);
   localparam int NSLICE = WIDTH / 4;
   localparam int CW     = $clog2(NSLICE + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, nxt;
   logic [WIDTH-1:0] a_q, b_q, res_q, r_q;
   logic [WIDTH-1:0] a_in, res_nx;
   logic [3:0]       s_q;
   logic             m_q, cy_q, eq_l;
   logic             pout_q, zero_q, eq_q;
   logic [CW-1:0]    cnt;
   logic             last;
   logic [3:0]       xa, xb, x, y, sl;
   logic [4:0]       sum;
   logic             co;

   assign a_in = bus.acc_sel ? r_q : bus.A;
   assign last = (cnt == CW'(NSLICE - 1));

   always_comb begin
      xa  = a_q[3:0];
      xb  = b_q[3:0];
      x   = '0;
      y   = '0;
      sum = '0;
      sl  = '0;
      co  = 1'b0;
      if (m_q) begin
         unique case (s_q)
            4'h0: sl = ~xa;
            4'h1: sl = ~(xa | xb);
            4'h2: sl = ~xa & xb;
            4'h3: sl = 4'h0;
            4'h4: sl = ~(xa & xb);
            4'h5: sl = ~xb;
            4'h6: sl = xa ^ xb;
            4'h7: sl = xa & ~xb;
            4'h8: sl = ~xa | xb;
            4'h9: sl = ~(xa ^ xb);
            4'hA: sl = xb;
            4'hB: sl = xa & xb;
            4'hC: sl = 4'hF;
            4'hD: sl = xa | ~xb;
            4'hE: sl = xa | xb;
            4'hF: sl = xa;
         endcase
      end else begin
         unique case (s_q)
            4'h0: begin x = xa;        y = 4'h0;      end
            4'h1: begin x = xa | xb;   y = 4'h0;      end
            4'h2: begin x = xa | ~xb;  y = 4'h0;      end
            4'h3: begin x = 4'hF;      y = 4'h0;      end
            4'h4: begin x = xa;        y = xa & ~xb;  end
            4'h5: begin x = xa | xb;   y = xa & ~xb;  end
            4'h6: begin x = xa;        y = ~xb;       end
            4'h7: begin x = xa & ~xb;  y = 4'hF;      end
            4'h8: begin x = xa;        y = xa & xb;   end
            4'h9: begin x = xa;        y = xb;        end
            4'hA: begin x = xa | ~xb;  y = xa & xb;   end
            4'hB: begin x = xa & xb;   y = 4'hF;      end
            4'hC: begin x = xa;        y = xa;        end
            4'hD: begin x = xa | xb;   y = xa;        end
            4'hE: begin x = xa | ~xb;  y = xa;        end
            4'hF: begin x = xa;        y = 4'hF;      end
         endcase
         sum = {1'b0, x} + {1'b0, y} + {4'b0, cy_q};
         sl  = sum[3:0];
         co  = sum[4];
      end
   end

   // New slice enters at the top; after NSLICE shifts the word is aligned.
   assign res_nx = (res_q >> 4) | (WIDTH'(sl) << (WIDTH - 4));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    if (bus.in_valid) nxt = RUN;
         RUN:     if (last) nxt = DONE;
         DONE:    if (bus.out_ready) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         res_q  <= '0;
         s_q    <= '0;
         m_q    <= 1'b0;
         cy_q   <= 1'b0;
         eq_l   <= 1'b0;
         cnt    <= '0;
         r_q    <= '0;
         pout_q <= 1'b0;
         zero_q <= 1'b1;
         eq_q   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_q   <= a_in;
                  b_q   <= bus.B;
                  s_q   <= bus.S;
                  m_q   <= bus.M;
                  cy_q  <= bus.Pin;
                  eq_l  <= (a_in == bus.B);
                  res_q <= '0;
                  cnt   <= '0;
               end
            end
            RUN: begin
               a_q   <= a_q >> 4;
               b_q   <= b_q >> 4;
               cy_q  <= co;
               res_q <= res_nx;
               cnt   <= cnt + 1'b1;
               if (last) begin
                  r_q    <= res_nx;
                  pout_q <= co;
                  zero_q <= (res_nx == '0);
                  eq_q   <= eq_l;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.R         = r_q;
   assign bus.Pout      = pout_q;
   assign bus.zero      = zero_q;
   assign bus.eq        = eq_q;
endmodule

// File: tb/tb_slice_alu.sv
// Bench for slice_alu at WIDTH 4, 16 and 64 against a
// full-width arithmetic reference model.
module tb_slice_alu;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [63:0] racc [3];

   always #5 clk = ~clk;

   slice_alu_if #(.WIDTH(4))  i4 ();
   slice_alu_if #(.WIDTH(16)) i16 ();
   slice_alu_if #(.WIDTH(64)) i64 ();

   slice_alu #(.WIDTH(4))  u4  (.clk(clk), .rst(rst), .bus(i4));
   slice_alu #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(i16));
   slice_alu #(.WIDTH(64)) u64 (.clk(clk), .rst(rst), .bus(i64));

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] wmask(int w);
      return (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
   endfunction

   function automatic int widx(int w);
      return (w == 4) ? 0 : (w == 16) ? 1 : 2;
   endfunction

   function automatic void model(int w, logic [63:0] ai, logic [63:0] bi,
                                 logic [3:0] s, bit m, bit pin,
                                 output logic [63:0] r, output bit po);
      logic [63:0] mk, a, b, na, nb, x, y;
      logic [64:0] sm;
      mk = wmask(w);
      a  = ai & mk;
      b  = bi & mk;
      na = ~a & mk;
      nb = ~b & mk;
      x  = '0;
      y  = '0;
      po = 1'b0;
      r  = '0;
      if (m) begin
         case (s)
            4'h0: r = na;
            4'h1: r = ~(a | b);
            4'h2: r = na & b;
            4'h3: r = '0;
            4'h4: r = ~(a & b);
            4'h5: r = nb;
            4'h6: r = a ^ b;
            4'h7: r = a & nb;
            4'h8: r = na | b;
            4'h9: r = ~(a ^ b);
            4'hA: r = b;
            4'hB: r = a & b;
            4'hC: r = mk;
            4'hD: r = a | nb;
            4'hE: r = a | b;
            default: r = a;
         endcase
         r = r & mk;
      end else begin
         case (s)
            4'h0: begin x = a;      y = 0;      end
            4'h1: begin x = a | b;  y = 0;      end
            4'h2: begin x = a | nb; y = 0;      end
            4'h3: begin x = mk;     y = 0;      end
            4'h4: begin x = a;      y = a & nb; end
            4'h5: begin x = a | b;  y = a & nb; end
            4'h6: begin x = a;      y = nb;     end
            4'h7: begin x = a & nb; y = mk;     end
            4'h8: begin x = a;      y = a & b;  end
            4'h9: begin x = a;      y = b;      end
            4'hA: begin x = a | nb; y = a & b;  end
            4'hB: begin x = a & b;  y = mk;     end
            4'hC: begin x = a;      y = a;      end
            4'hD: begin x = a | b;  y = a;      end
            4'hE: begin x = a | nb; y = a;      end
            default: begin x = a;   y = mk;     end
         endcase
         sm = {1'b0, x} + {1'b0, y} + {64'd0, pin};
         r  = sm[63:0] & mk;
         po = sm[w];
      end
   endfunction

   task automatic drive(int w, bit v, logic [63:0] a, logic [63:0] b,
                        logic [3:0] s, bit m, bit pin, bit acc, bit ordy);
      case (w)
         4: begin
            i4.in_valid = v; i4.A = a[3:0]; i4.B = b[3:0]; i4.S = s;
            i4.M = m; i4.Pin = pin; i4.acc_sel = acc; i4.out_ready = ordy;
         end
         16: begin
            i16.in_valid = v; i16.A = a[15:0]; i16.B = b[15:0]; i16.S = s;
            i16.M = m; i16.Pin = pin; i16.acc_sel = acc; i16.out_ready = ordy;
         end
         default: begin
            i64.in_valid = v; i64.A = a; i64.B = b; i64.S = s;
            i64.M = m; i64.Pin = pin; i64.acc_sel = acc; i64.out_ready = ordy;
         end
      endcase
   endtask

   task automatic junk(int w, bit v, bit ordy);
      drive(w, v, {$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), ordy);
   endtask

   function automatic void rd(int w, output bit ov, output bit ir,
                              output logic [63:0] r, output bit po,
                              output bit z, output bit e);
      case (w)
         4: begin
            ov = i4.out_valid; ir = i4.in_ready; r = 64'(i4.R);
            po = i4.Pout; z = i4.zero; e = i4.eq;
         end
         16: begin
            ov = i16.out_valid; ir = i16.in_ready; r = 64'(i16.R);
            po = i16.Pout; z = i16.zero; e = i16.eq;
         end
         default: begin
            ov = i64.out_valid; ir = i64.in_ready; r = i64.R;
            po = i64.Pout; z = i64.zero; e = i64.eq;
         end
      endcase
   endfunction

   task automatic op(int w, logic [63:0] a, logic [63:0] b, logic [3:0] s,
                     bit m, bit pin, bit acc, int hold,
                     output logic [63:0] gr, output bit gp,
                     output bit gz, output bit ge);
      int k, cnt;
      logic [63:0] mk, aa, er, r2;
      bit ep, ov, ir, po, z, e, p2, z2, e2;
      k  = widx(w);
      mk = wmask(w);
      aa = acc ? racc[k] : (a & mk);
      model(w, aa, b, s, m, pin, er, ep);
      @(negedge clk);
      rd(w, ov, ir, gr, po, z, e);
      check("ready_before", 64'(ir), 64'd1);
      drive(w, 1'b1, a, b, s, m, pin, acc, 1'b0);
      @(posedge clk);
      #1;
      junk(w, 1'b0, 1'b0);
      rd(w, ov, ir, gr, po, z, e);
      check("busy_after_accept", 64'({ov, ir}), 64'd0);
      cnt = 0;
      while (!ov && cnt < 40) begin
         @(posedge clk);
         #1;
         cnt++;
         junk(w, 1'($urandom), 1'b0);
         rd(w, ov, ir, gr, po, z, e);
      end
      check("latency", 64'(cnt), 64'(w / 4));
      check("R", gr, er);
      check("Pout", 64'(po), 64'(ep));
      check("zero", 64'(z), 64'(er == 0));
      check("eq", 64'(e), 64'(aa == (b & mk)));
      gp = po;
      gz = z;
      ge = e;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         junk(w, 1'b1, 1'b0);
         rd(w, ov, ir, r2, p2, z2, e2);
         check("hold_R", r2, er);
         check("hold_flags", 64'({p2, z2, e2}), 64'({po, z, e}));
         check("hold_hs", 64'({ov, ir}), 64'b10);
      end
      junk(w, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      junk(w, 1'b0, 1'b0);
      rd(w, ov, ir, r2, p2, z2, e2);
      check("back_idle", 64'({ov, ir}), 64'b01);
      check("R_persist", r2, er);
      racc[k] = er;
   endtask

   initial begin : main
      logic [63:0] r;
      bit p, z, e, ov, ir;
      int ws [3];
      ws = '{4, 64, 16};
      for (int k = 0; k < 3; k++) racc[k] = '0;
      drive(4, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(16, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(64, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      rd(16, ov, ir, r, p, z, e);
      check("rst_hs", 64'({ov, ir}), 64'b01);
      check("rst_R", r, 64'd0);
      check("rst_flags", 64'({p, z, e}), 64'b010);

      // accumulate right after reset starts from zero
      op(16, 64'h1234, 64'h0005, 4'h9, 0, 0, 1, 0, r, p, z, e);
      check("acc_after_rst", r, 64'h0005);
      op(16, 64'hFFFF, 64'h0001, 4'h9, 0, 0, 0, 0, r, p, z, e);
      check("ovf_add", 64'({r[15:0], p, z, e}), {45'd0, 16'h0000, 3'b110});
      op(16, 64'h1234, 64'h1234, 4'h6, 0, 1, 0, 0, r, p, z, e);
      check("sub_eq", 64'({r[15:0], p, z, e}), {45'd0, 16'h0000, 3'b111});
      op(16, 64'h1234, 64'h1234, 4'h6, 0, 0, 0, 0, r, p, z, e);
      check("sub_m1", 64'({r[15:0], p, z}), {46'd0, 16'hFFFF, 2'b00});
      op(16, 64'hF0F0, 64'hFF00, 4'h6, 1, 0, 0, 0, r, p, z, e);
      check("xor", 64'({r[15:0], p}), {47'd0, 16'h0FF0, 1'b0});
      op(16, 64'h0000, 64'h0FF0, 4'h6, 1, 0, 1, 0, r, p, z, e);
      check("acc_xor", 64'({r[15:0], z}), {47'd0, 16'h0000, 1'b1});
      op(16, 64'h1234, 64'h0000, 4'hF, 1, 0, 0, 3, r, p, z, e);
      check("bp_R", r, 64'h1234);

      // reset on the second RUN cycle, colliding with a new request
      @(negedge clk);
      drive(16, 1, 64'hAAAA, 64'h5555, 4'h9, 0, 1, 0, 0);
      @(posedge clk);
      #1;
      junk(16, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      junk(16, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      junk(16, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) racc[k] = '0;
      rd(16, ov, ir, r, p, z, e);
      check("midrun_rst_hs", 64'({ov, ir}), 64'b01);
      check("midrun_rst_R", r, 64'd0);
      check("midrun_rst_flags", 64'({p, z, e}), 64'b010);
      op(16, 64'h0101, 64'h0202, 4'h9, 0, 1, 0, 0, r, p, z, e);
      check("after_rst_op", r, 64'h0304);

      foreach (ws[wi]) begin
         for (int s = 0; s < 16; s++) begin
            for (int mp = 0; mp < 4; mp++) begin
               op(ws[wi], {$urandom, $urandom}, {$urandom, $urandom},
                  4'(s), mp[1], mp[0], ($urandom_range(0, 3) == 0),
                  0, r, p, z, e);
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/slice_alu.md
SLICE_ALU -- requirements
Module: slice_alu

Interface
REQ-001 Parameter WIDTH, default 16: operand/result width; SHALL be a multiple of 4, range 4..64; NSLICE = WIDTH/4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operation request.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 A, B  input  WIDTH  operands.
REQ-007 S  input  4  function select.
REQ-008 M  input  1  1 = logic mode, 0 = arithmetic mode.
REQ-009 Pin  input  1  carry-in, active-high (1 = add one).
REQ-010 acc_sel  input  1  1 = use previous R in place of A.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer takes result.
REQ-013 R  output  WIDTH  result.
REQ-014 Pout  output  1  carry-out of MSB slice.
REQ-015 zero  output  1  R == 0.
REQ-016 eq  output  1  latched A == B (A after acc_sel substitution).

Function
REQ-017 FSM states IDLE, RUN, DONE; in_ready SHALL be 1 only in IDLE.
REQ-018 IDLE: on in_valid=1, SHALL latch A (or R if acc_sel=1), B, S, M, Pin, clear slice counter, go to RUN.
REQ-019 RUN: SHALL compute exactly one 4-bit slice per cycle, LSB slice first; carry between slices held in a register, initialised to latched Pin.
REQ-020 After NSLICE RUN cycles SHALL enter DONE; out_valid SHALL rise exactly NSLICE cycles after the accepting edge.
REQ-021 DONE: R, Pout, zero, eq SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 DONE with out_ready=1: SHALL return to IDLE next cycle; R SHALL persist (used by acc_sel) until overwritten by a later completion.
REQ-023 R, Pout, zero, eq SHALL update only at DONE entry; intermediate slices not visible on R.
REQ-024 Logic mode (M=1), bitwise, Pout=0: S0 ~A; 1 ~(A|B); 2 ~A&B; 3 0; 4 ~(A&B); 5 ~B; 6 A^B; 7 A&~B; 8 ~A|B; 9 ~(A^B); A B; B A&B; C all-ones; D A|~B; E A|B; F A.
REQ-025 Arithmetic mode (M=0): R = X + Y + Pin mod 2^WIDTH, Pout = bit WIDTH of full sum; (X,Y) per S: 0 (A,0); 1 (A|B,0); 2 (A|~B,0); 3 (ones,0); 4 (A,A&~B); 5 (A|B,A&~B); 6 (A,~B); 7 (A&~B,ones); 8 (A,A&B); 9 (A,B); A (A|~B,A&B); B (A&B,ones); C (A,A); D (A|B,A); E (A|~B,A); F (A,ones).
REQ-026 Slice-serial result SHALL equal the full-width computation of REQ-024/025 bit-exactly for every WIDTH.
REQ-027 in_valid in RUN or DONE SHALL be ignored (not queued); inputs other than out_ready SHALL not affect RUN/DONE.
REQ-028 acc_sel=1 after reset SHALL use R=0.

Reset
REQ-029 rst=1 at any edge, including mid-RUN or in DONE, SHALL force IDLE, abort the operation, and set R=0, Pout=0, zero=1, eq=0, out_valid=0, in_ready=1 from the next cycle.
REQ-030 rst SHALL dominate in_valid and out_ready on the same edge.

Verification (WIDTH=16 unless stated)
REQ-031 A=FFFF, B=0001, S=9, M=0, Pin=0 -> out_valid 4 cycles after accept, R=0000, Pout=1, zero=1, eq=0.
REQ-032 A=B=1234, S=6, M=0, Pin=1 -> R=0000, Pout=1, zero=1, eq=1; same with Pin=0 -> R=FFFF, Pout=0, zero=0.
REQ-033 A=F0F0, B=FF00, S=6, M=1 -> R=0FF0, Pout=0; then acc_sel=1, B=0FF0, S=6, M=1 -> R=0000, zero=1.
REQ-034 Backpressure: hold out_ready=0 for 3 cycles in DONE, pulse in_valid -> R/flags stable, in_ready=0, request ignored; out_ready=1 -> IDLE next cycle.
REQ-035 rst asserted on 2nd RUN cycle -> next cycle out_valid=0, in_ready=1, R=0000, zero=1; fresh request then completes normally.
REQ-036 WIDTH=4 and WIDTH=64 random sweep over all S, M, Pin -> results match REQ-024/025 model; latency 1 and 16 cycles respectively.
